sprite_scan_reader: RTL and testbench
=====================================

Name: sprite_scan_reader

Overview:
- Consumer end of the object-position path: samples an object's x/y position (written by the motion/translate logic) once per frame and compares it against the raster scan.
- Outputs a registered "sprite pixel on" flag plus a row/column address into the sprite bitmap ROM.
- Sits between the object motion blocks and the VGA pixel mux.
- Latching at frame start prevents tearing when the position changes mid-frame.

Parameters:
- SPR_W, 16, sprite width in pixels (power of two, 2..64)
- SPR_H, 16, sprite height in lines (power of two, 2..64)
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel strobe; pipeline advances only when high
- frame_start  in  1  one-clk pulse at the start of vertical blanking
- hcount  in  10  current scan column
- vcount  in  10  current scan line
- x_in  in  10  object x position, unsigned, may wrap
- y_in  in  10  object y position, unsigned
- pix_on  out  1  scan point is inside the sprite (2 pix_en stages late)
- spr_col  out  log2(SPR_W)  column offset into the sprite bitmap
- spr_row  out  log2(SPR_H)  row offset into the sprite bitmap
- pos_valid  out  1  a position has been latched since reset
- x_lat  out  10  currently latched x, for debug and collision logic

Behaviour:
- Reset (async, rst_n=0) values:
  - pix_on=0, spr_col=0, spr_row=0
  - pos_valid=0, x_lat=0, internal y_lat=0
  - state=WAIT_FRAME
  - pipeline stage registers cleared
- Latch rule:
  - On any clk where frame_start=1, x_lat<=x_in and y_lat<=y_in, independent of pix_en.
  - x_in/y_in are ignored at all other times.
- State machine (evaluated on clk):
  - WAIT_FRAME: pix_on is forced 0. On frame_start go to SCAN and set pos_valid=1. pos_valid stays 1 until reset.
  - SCAN: normal comparison. frame_start stays in SCAN and re-latches.
  - No other states. Reset mid-frame returns to WAIT_FRAME, and pix_on stays 0 until the next frame_start.
- Hit test, all arithmetic 11-bit zero-extended:
  - h_hit = (hcount >= x_lat) && (hcount < x_lat + SPR_W)
  - v_hit = (vcount >= y_lat) && (vcount < y_lat + SPR_H)
  - visible = (hcount < H_ACTIVE) && (vcount < V_ACTIVE)
  - hit = h_hit && v_hit && visible && state==SCAN
  - No horizontal or vertical wrap: a sprite with x_lat=1020 is invisible, and one with x_lat=630 is clipped to columns 630..639.
- Offsets:
  - spr_col = (hcount - x_lat) truncated to log2(SPR_W) bits.
  - spr_row = (vcount - y_lat) truncated to log2(SPR_H) bits.
  - Outputs are meaningful only when pix_on=1; otherwise they hold the last computed value.
- Pipeline (registers update only when pix_en=1):
  - Stage 1 registers hcount, vcount and the compare results.
  - Stage 2 registers pix_on, spr_col and spr_row.
  - Latency is exactly 2 pix_en-qualified clocks from the hcount/vcount sample to the output.
  - With pix_en=0 all stage registers hold.
- Simultaneous events:
  - frame_start and pix_en in the same clk: the compare in that clk uses the OLD x_lat/y_lat; the new values apply from the next clk.
  - frame_start while in WAIT_FRAME with pix_en=1: that cycle's stage-1 hit is 0.

Test Plan:
1. Reset, then with no frame_start scan the full frame at x_in=100, y_in=50 -> pix_on never 1, pos_valid=0.
2. Pulse frame_start with x_in=100, y_in=50, then scan with pix_en=1 every clk -> pos_valid=1.
   - pix_on=1 exactly for hcount 100..115 on lines 50..65, appearing 2 clks after the sample.
   - At hcount=107, vcount=53: spr_col=7, spr_row=3.
3. Change x_in to 200 mid-frame -> the sprite stays at 100 until the next frame_start, then moves to 200..215.
4. x_in=1020 (wrapped by the motion logic) -> zero pix_on pixels in the frame. x_in=630 -> pix_on only for hcount 630..639.
5. pix_en high every 4th clk -> pix_on timing is measured in strobes (still 2), and the outputs hold between strobes.
6. Assert rst_n=0 mid-line while pix_on=1 -> pix_on drops to 0 immediately (async). After release it stays 0 until frame_start, then resumes with the newly latched position.

Source files
------------

// File: rtl/sprite_scan_reader.sv
// Sprite scan reader: latches an object position once per frame and compares it
// against the raster scan, producing a two-stage pipelined pixel-on flag and bitmap offsets.
module sprite_scan_reader #(
   parameter int SPR_W    = 16,
   parameter int SPR_H    = 16,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   localparam int COL_W   = $clog2(SPR_W),
   localparam int ROW_W   = $clog2(SPR_H)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pix_en,
   input  logic             frame_start,
   input  logic [9:0]       hcount,
   input  logic [9:0]       vcount,
   input  logic [9:0]       x_in,
   input  logic [9:0]       y_in,
   output logic             pix_on,
   output logic [COL_W-1:0] spr_col,
   output logic [ROW_W-1:0] spr_row,
   output logic             pos_valid,
   output logic [9:0]       x_lat
);

   typedef enum logic [0:0] {
      WAIT_FRAME = 1'b0,
      SCAN       = 1'b1
   } state_t;

   state_t           state_r;
   logic [9:0]       x_lat_r;
   logic [9:0]       y_lat_r;
   logic             pos_valid_r;

   logic             s1_hit_r;
   logic [COL_W-1:0] s1_col_r;
   logic [ROW_W-1:0] s1_row_r;
   logic             pix_on_r;
   logic [COL_W-1:0] spr_col_r;
   logic [ROW_W-1:0] spr_row_r;

   logic [10:0]      h_ext_s;
   logic [10:0]      v_ext_s;
   logic [10:0]      x_ext_s;
   logic [10:0]      y_ext_s;
   logic             h_hit_s;
   logic             v_hit_s;
   logic             vis_s;
   logic             hit_s;
   logic [COL_W-1:0] col_s;
   logic [ROW_W-1:0] row_s;

   // Zero-extend to 11 bits so x_lat + SPR_W cannot wrap past 1023
   assign h_ext_s = {1'b0, hcount};
   assign v_ext_s = {1'b0, vcount};
   assign x_ext_s = {1'b0, x_lat_r};
   assign y_ext_s = {1'b0, y_lat_r};

   assign h_hit_s = (h_ext_s >= x_ext_s) && (h_ext_s < (x_ext_s + 11'(SPR_W)));
   assign v_hit_s = (v_ext_s >= y_ext_s) && (v_ext_s < (y_ext_s + 11'(SPR_H)));
   assign vis_s   = (h_ext_s < 11'(H_ACTIVE)) && (v_ext_s < 11'(V_ACTIVE));

   // Offsets only need the low bits, so subtract in the truncated width directly
   assign col_s = hcount[COL_W-1:0] - x_lat_r[COL_W-1:0];
   assign row_s = vcount[ROW_W-1:0] - y_lat_r[ROW_W-1:0];

   // Hit qualification: nothing is shown until a position has been latched
   always_comb begin
      hit_s = 1'b0;
      if (state_r == SCAN) begin
         hit_s = h_hit_s && v_hit_s && vis_s;
      end else begin
         hit_s = 1'b0;
      end
   end

   // Frame FSM and position latch; latching ignores pix_en so blanking strobes never miss it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= WAIT_FRAME;
         x_lat_r     <= 10'd0;
         y_lat_r     <= 10'd0;
         pos_valid_r <= 1'b0;
      end else begin
         if (frame_start) begin
            x_lat_r <= x_in;
            y_lat_r <= y_in;
         end else begin
            x_lat_r <= x_lat_r;
            y_lat_r <= y_lat_r;
         end
         case (state_r)
            WAIT_FRAME: begin
               if (frame_start) begin
                  state_r     <= SCAN;
                  pos_valid_r <= 1'b1;
               end else begin
                  state_r     <= WAIT_FRAME;
               end
            end
            SCAN: begin
               state_r <= SCAN;
            end
            default: begin
               state_r <= WAIT_FRAME;
            end
         endcase
      end
   end

   // Two-stage strobe-qualified pipeline; compares use the pre-latch position in a frame_start cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_hit_r  <= 1'b0;
         s1_col_r  <= '0;
         s1_row_r  <= '0;
         pix_on_r  <= 1'b0;
         spr_col_r <= '0;
         spr_row_r <= '0;
      end else if (pix_en) begin
         s1_hit_r  <= hit_s;
         s1_col_r  <= col_s;
         s1_row_r  <= row_s;
         pix_on_r  <= s1_hit_r;
         spr_col_r <= s1_col_r;
         spr_row_r <= s1_row_r;
      end else begin
         s1_hit_r  <= s1_hit_r;
         s1_col_r  <= s1_col_r;
         s1_row_r  <= s1_row_r;
         pix_on_r  <= pix_on_r;
         spr_col_r <= spr_col_r;
         spr_row_r <= spr_row_r;
      end
   end

   assign pix_on    = pix_on_r;
   assign spr_col   = spr_col_r;
   assign spr_row   = spr_row_r;
   assign pos_valid = pos_valid_r;
   assign x_lat     = x_lat_r;

endmodule

// File: tb/tb_sprite_scan_reader.sv
// Directed bench for sprite_scan_reader: scans windows of the raster and checks
// pix_on / offsets against hand-given sprite boxes.
module tb_sprite_scan_reader;

   logic       clk;
   logic       rst_n;
   logic       pix_en;
   logic       frame_start;
   logic [9:0] hcount;
   logic [9:0] vcount;
   logic [9:0] x_in;
   logic [9:0] y_in;
   logic       pix_on;
   logic [3:0] spr_col;
   logic [3:0] spr_row;
   logic       pos_valid;
   logic [9:0] x_lat;

   int checks_total;
   int checks_passed;

   sprite_scan_reader #(
      .SPR_W(16), .SPR_H(16), .H_ACTIVE(640), .V_ACTIVE(480)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .frame_start(frame_start),
      .hcount(hcount), .vcount(vcount), .x_in(x_in), .y_in(y_in),
      .pix_on(pix_on), .spr_col(spr_col), .spr_row(spr_row),
      .pos_valid(pos_valid), .x_lat(x_lat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      checks_total++;
      if (obs == exp) begin
         checks_passed++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_frame(input int x, input int y);
      x_in        = 10'(x);
      y_in        = 10'(y);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   // Scan a window; each strobe checks the output for the coordinate of the previous strobe
   task automatic scan(input int v0, input int v1, input int h0, input int h1,
                       input int xlo, input int ylo, input bit act, input int period,
                       output int hits, output int mn, output int mx, output int bad);
      int   ph;
      int   pv;
      bit   have;
      bit   exp_hit;
      logic hold_on;
      logic [3:0] hold_c;
      logic [3:0] hold_r;
      hits = 0; mn = 9999; mx = -1; bad = 0; have = 1'b0; ph = 0; pv = 0;
      hold_on = pix_on; hold_c = spr_col; hold_r = spr_row;
      for (int v = v0; v <= v1; v++) begin
         for (int h = h0; h <= h1; h++) begin
            for (int k = 0; k < period; k++) begin
               hcount = 10'(h);
               vcount = 10'(v);
               pix_en = (k == period - 1);
               tick();
               if (pix_en) begin
                  if (have) begin
                     exp_hit = act && (ph >= xlo) && (ph < xlo + 16) && (pv >= ylo) &&
                               (pv < ylo + 16) && (ph < 640) && (pv < 480);
                     if (pix_on !== exp_hit) bad++;
                     if (pix_on === 1'b1) begin
                        hits++;
                        if (ph < mn) mn = ph;
                        if (ph > mx) mx = ph;
                        if (spr_col !== 4'(ph - xlo) || spr_row !== 4'(pv - ylo)) bad++;
                     end
                  end
                  have = 1'b1; ph = h; pv = v;
                  hold_on = pix_on; hold_c = spr_col; hold_r = spr_row;
               end else if (pix_on !== hold_on || spr_col !== hold_c || spr_row !== hold_r) begin
                  bad++;
               end
            end
         end
      end
      pix_en = 1'b0;
   endtask

   initial begin
      int hits, mn, mx, bad;
      checks_total = 0; checks_passed = 0;
      rst_n = 1'b0; pix_en = 1'b0; frame_start = 1'b0;
      hcount = 10'd0; vcount = 10'd0; x_in = 10'd100; y_in = 10'd50;
      #2;
      check_val("rst_pix_on", int'(pix_on), 0);
      check_val("rst_pos_valid", int'(pos_valid), 0);
      check_val("rst_x_lat", int'(x_lat), 0);
      check_val("rst_spr_col", int'(spr_col), 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // 1: no frame_start yet, nothing visible
      scan(48, 67, 95, 120, 100, 50, 1'b0, 1, hits, mn, mx, bad);
      check_val("t1_hits", hits, 0);
      check_val("t1_bad", bad, 0);
      check_val("t1_pos_valid", int'(pos_valid), 0);

      // 2: latch 100,50 and scan the sprite area
      pulse_frame(100, 50);
      check_val("t2_pos_valid", int'(pos_valid), 1);
      check_val("t2_x_lat", int'(x_lat), 100);
      scan(48, 67, 95, 120, 100, 50, 1'b1, 1, hits, mn, mx, bad);
      check_val("t2_hits", hits, 256);
      check_val("t2_bad", bad, 0);
      check_val("t2_min_h", mn, 100);
      check_val("t2_max_h", mx, 115);
      pix_en = 1'b1; hcount = 10'd107; vcount = 10'd53;
      tick();
      check_val("t2_lat_stage1_only", int'(pix_on), 0);
      hcount = 10'd0;
      tick();
      check_val("t2_pix_107_53", int'(pix_on), 1);
      check_val("t2_col_107", int'(spr_col), 7);
      check_val("t2_row_53", int'(spr_row), 3);
      pix_en = 1'b0;

      // 3: x_in changes mid-frame without frame_start, sprite stays put
      x_in = 10'd200;
      scan(50, 51, 95, 220, 100, 50, 1'b1, 1, hits, mn, mx, bad);
      check_val("t3_hold_hits", hits, 32);
      check_val("t3_hold_min", mn, 100);
      check_val("t3_hold_bad", bad, 0);
      pulse_frame(200, 50);
      scan(50, 51, 95, 220, 200, 50, 1'b1, 1, hits, mn, mx, bad);
      check_val("t3_move_hits", hits, 32);
      check_val("t3_move_min", mn, 200);
      check_val("t3_move_max", mx, 215);
      check_val("t3_move_bad", bad, 0);

      // 4: wrapped position is invisible, right edge clips at 639
      pulse_frame(1020, 50);
      scan(50, 51, 1000, 1023, 1020, 50, 1'b1, 1, hits, mn, mx, bad);
      check_val("t4_wrap_hits", hits, 0);
      check_val("t4_wrap_bad", bad, 0);
      pulse_frame(630, 50);
      scan(50, 51, 620, 660, 630, 50, 1'b1, 1, hits, mn, mx, bad);
      check_val("t4_clip_hits", hits, 20);
      check_val("t4_clip_max", mx, 639);
      check_val("t4_clip_bad", bad, 0);

      // 5: strobe every 4th clock
      pulse_frame(100, 50);
      scan(52, 52, 96, 120, 100, 50, 1'b1, 4, hits, mn, mx, bad);
      check_val("t5_hits", hits, 16);
      check_val("t5_bad", bad, 0);

      // frame_start with pix_en in the same clock compares against the old position
      frame_start = 1'b1; x_in = 10'd200; pix_en = 1'b1; hcount = 10'd100; vcount = 10'd52;
      tick();
      frame_start = 1'b0; hcount = 10'd0;
      tick();
      check_val("sim_old_pos_hit", int'(pix_on), 1);
      check_val("sim_new_x_lat", int'(x_lat), 200);
      hcount = 10'd100;
      tick();
      hcount = 10'd0;
      tick();
      check_val("sim_new_pos_miss", int'(pix_on), 0);

      // 6: async reset while pix_on=1
      pulse_frame(100, 50);
      pix_en = 1'b1; hcount = 10'd105; vcount = 10'd52;
      tick();
      hcount = 10'd106;
      tick();
      check_val("t6_pre_rst_on", int'(pix_on), 1);
      rst_n = 1'b0;
      #1;
      check_val("t6_async_pix_on", int'(pix_on), 0);
      check_val("t6_async_pos_valid", int'(pos_valid), 0);
      check_val("t6_async_x_lat", int'(x_lat), 0);
      pix_en = 1'b0;
      tick();
      rst_n = 1'b1;
      x_in = 10'd300; y_in = 10'd50;
      scan(52, 52, 295, 320, 300, 50, 1'b0, 1, hits, mn, mx, bad);
      check_val("t6_wait_hits", hits, 0);
      check_val("t6_wait_bad", bad, 0);
      frame_start = 1'b1; pix_en = 1'b1; hcount = 10'd300; vcount = 10'd52;
      tick();
      frame_start = 1'b0; hcount = 10'd0;
      tick();
      check_val("t6_fs_in_wait_hit0", int'(pix_on), 0);
      check_val("t6_pos_valid", int'(pos_valid), 1);
      pix_en = 1'b0;
      scan(52, 52, 295, 320, 300, 50, 1'b1, 1, hits, mn, mx, bad);
      check_val("t6_resume_hits", hits, 16);
      check_val("t6_resume_min", mn, 300);
      check_val("t6_resume_bad", bad, 0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
